memory_responder: RTL and testbench

- Target end of the core's memory request/response interface: accepts `mem_in_type` requests from an instruction or data port and returns `mem_out_type` responses.
- Backs a byte-writable, word-organised on-chip RAM with a configurable fixed response latency.
- Has a one-entry pending slot, so a request issued while another is in flight is not lost.
- Used in simulation tops and FPGA builds: one instance per core memory port.

---
 rtl/configure.sv | 5 +
 rtl/wires.sv | 23 ++
 rtl/memory_responder_ram.sv | 24 ++
 rtl/memory_responder.sv | 130 +++++++++++++
 tb/tb_memory_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/configure.sv
// Platform defaults for the on-chip memory responders.
package configure;
    localparam int unsigned MEM_DEPTH   = 4096;
    localparam int unsigned MEM_LATENCY = 1;
endpackage

// File: rtl/wires.sv
// Core memory-port request/response records plus memory_responder's local state and request types.
package wires;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic {IDLE, BUSY} mr_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mr_req_t;
endpackage

// File: rtl/memory_responder_ram.sv
// DEPTH x 32 word array: byte-enabled synchronous write, registered read, no reset.
module memory_responder_ram #(
    parameter  int unsigned DEPTH = 4096,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/memory_responder.sv
// Fixed-latency RAM target for a core memory port, with a one-entry pending slot.
// Define MEMORY_RESPONDER_RANGE_CHECK_EN to flag out-of-range accesses on err instead of wrapping.
module memory_responder
    import wires::*;
#(
    parameter int unsigned DEPTH   = configure::MEM_DEPTH,
    parameter int unsigned LATENCY = configure::MEM_LATENCY,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  mem_in,
    output mem_out_type mem_out,
    output logic        overrun,
    output logic        err
);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    mr_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mr_req_t       act_q, act_d, pend_q, pend_d, new_req;
    logic          pend_vld_q, pend_vld_d;
    logic          overrun_q, overrun_d;
    logic          ready_q, zero_q;
    logic          access, is_wr, oor, unused_ok;
    logic [31:0]   offs, ram_rdata;
    logic [29:0]   idx;

    assign new_req = '{addr: mem_in.mem_addr, wdata: mem_in.mem_wdata, wstrb: mem_in.mem_wstrb};
    assign access  = (state_q == BUSY) && (cnt_q == '0);
    assign is_wr   = |act_q.wstrb;
    assign offs    = act_q.addr - BASE;
    assign idx     = offs[31:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = overrun_q;
        case (state_q)
            IDLE: begin
                if (mem_in.mem_valid) begin
                    act_d   = new_req;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (mem_in.mem_valid) begin
                        if (!pend_vld_q) begin
                            pend_d     = new_req;
                            pend_vld_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (pend_vld_q) begin
                    // Older pending request goes first; a same-edge request refills the slot.
                    act_d      = pend_q;
                    cnt_d      = CNT_INIT;
                    pend_d     = new_req;
                    pend_vld_d = mem_in.mem_valid;
                end else if (mem_in.mem_valid) begin
                    act_d = new_req;
                    cnt_d = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    logic err_q;
    assign oor = (act_q.addr < BASE) || (|idx[29:AW]);
    assign err = err_q;
    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= access && oor;
    end
`else
    assign oor = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            overrun_q  <= overrun_d;
            ready_q    <= access;
            if (access) zero_q <= is_wr || oor;
        end
    end

    always_ff @(posedge clock) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

    // A reset edge must not let the abandoned active request touch the array.
    memory_responder_ram #(.DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .we_i    (access && is_wr && !oor && !reset),
        .re_i    (access && !is_wr && !reset),
        .addr_i  (idx[AW-1:0]),
        .wdata_i (act_q.wdata),
        .wstrb_i (act_q.wstrb),
        .rdata_o (ram_rdata)
    );

    assign mem_out   = '{mem_ready: ready_q, mem_rdata: zero_q ? 32'h0 : ram_rdata};
    assign overrun   = overrun_q;
    assign unused_ok = ^{mem_in.mem_instr, offs[1:0], idx[29:AW]};
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: three responders (LATENCY 1/2/3) exercised with hand-computed expectations.
module tb_memory_responder;
    import wires::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    mem_in_type  in1, in2, in3;
    mem_out_type out1, out2, out3;
    logic        ov1, ov2, ov3, er1, er2, er3;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    memory_responder #(.DEPTH(1024), .LATENCY(1), .BASE(32'h0)) u1 (
        .clock(clk), .reset(reset), .mem_in(in1), .mem_out(out1), .overrun(ov1), .err(er1));
    memory_responder #(.DEPTH(64), .LATENCY(2), .BASE(32'h0)) u2 (
        .clock(clk), .reset(reset), .mem_in(in2), .mem_out(out2), .overrun(ov2), .err(er2));
    memory_responder #(.DEPTH(64), .LATENCY(3), .BASE(32'h0)) u3 (
        .clock(clk), .reset(reset), .mem_in(in3), .mem_out(out3), .overrun(ov3), .err(er3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        mem_in_type r;
        r = '{mem_valid: v, mem_instr: 1'b0, mem_addr: a, mem_wdata: wd, mem_wstrb: st};
        case (d)
            1:       in1 = r;
            2:       in2 = r;
            default: in3 = r;
        endcase
    endtask

    // Issue one request from idle and advance to its ready cycle (LATENCY edges after sampling).
    task automatic single(input int d, input int lat, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st);
        drive(d, 1'b1, a, wd, st);
        tick();
        drive(d, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (lat) tick();
    endtask

    task automatic test_reset();
        drive(1, 1'b0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0);
        drive(3, 1'b0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out1.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got %b want 0", out1.mem_ready); end
        checks++; if (out1.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata1 got %h want 0", out1.mem_rdata); end
        checks++; if (ov1 !== 1'b0 || er1 !== 1'b0) begin failures++; $display("FAIL reset_flags1 got ov=%b err=%b want 0 0", ov1, er1); end
        checks++; if (out2.mem_ready !== 1'b0 || out2.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_out2 got %b/%h want 0/0", out2.mem_ready, out2.mem_rdata); end
        checks++; if (out3.mem_ready !== 1'b0 || out3.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_out3 got %b/%h want 0/0", out3.mem_ready, out3.mem_rdata); end
        checks++; if (ov2 !== 1'b0 || ov3 !== 1'b0 || er2 !== 1'b0 || er3 !== 1'b0) begin failures++; $display("FAIL reset_flags23 got %b%b%b%b want 0000", ov2, ov3, er2, er3); end
    endtask

    task automatic test_l1_write_read();
        drive(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        checks++; if (out1.mem_ready !== 1'b0) begin failures++; $display("FAIL l1_wr_early got %b want 0", out1.mem_ready); end
        drive(1, 1'b0, 0, 0, 0);
        tick();
        checks++; if (out1.mem_ready !== 1'b1 || out1.mem_rdata !== 32'h0) begin failures++; $display("FAIL l1_wr_rsp got %b/%h want 1/00000000", out1.mem_ready, out1.mem_rdata); end
        tick();
        checks++; if (out1.mem_ready !== 1'b0) begin failures++; $display("FAIL l1_wr_pulse got %b want 0", out1.mem_ready); end
        single(1, 1, 32'h10, 32'h0, 4'h0);
        checks++; if (out1.mem_ready !== 1'b1 || out1.mem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL l1_rd got %b/%h want 1/deadbeef", out1.mem_ready, out1.mem_rdata); end
        tick(); tick();
        checks++; if (out1.mem_ready !== 1'b0 || out1.mem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL l1_rd_hold got %b/%h want 0/deadbeef", out1.mem_ready, out1.mem_rdata); end
    endtask

    task automatic test_byte_strobe();
        single(1, 1, 32'h20, 32'h11223344, 4'hF);
        tick();
        single(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        checks++; if (out1.mem_ready !== 1'b1 || out1.mem_rdata !== 32'h0) begin failures++; $display("FAIL strb_wr_rsp got %b/%h want 1/00000000", out1.mem_ready, out1.mem_rdata); end
        tick();
        single(1, 1, 32'h20, 32'h0, 4'h0);
        checks++; if (out1.mem_rdata !== 32'h11BB33DD) begin failures++; $display("FAIL strb_rd got %h want 11bb33dd", out1.mem_rdata); end
        tick();
    endtask

    task automatic test_overrun_l3();
        int n;
        single(3, 3, 32'h0, 32'hA0A0A0A0, 4'hF); tick();
        single(3, 3, 32'h4, 32'hA4A4A4A4, 4'hF); tick();
        single(3, 3, 32'h8, 32'hA8A8A8A8, 4'hF);
        checks++; if (out3.mem_ready !== 1'b1 || out3.mem_rdata !== 32'h0) begin failures++; $display("FAIL l3_wr_rsp got %b/%h want 1/00000000", out3.mem_ready, out3.mem_rdata); end
        tick();
        drive(3, 1'b1, 32'h0, 0, 0); tick();
        checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL l3_ov_early0 got %b want 0", ov3); end
        drive(3, 1'b1, 32'h4, 0, 0); tick();
        checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL l3_ov_early1 got %b want 0", ov3); end
        drive(3, 1'b1, 32'h8, 0, 0); tick();
        checks++; if (ov3 !== 1'b1 || out3.mem_ready !== 1'b0) begin failures++; $display("FAIL l3_drop got ov=%b rdy=%b want 1 0", ov3, out3.mem_ready); end
        drive(3, 1'b0, 0, 0, 0); tick();
        checks++; if (out3.mem_ready !== 1'b1 || out3.mem_rdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL l3_rsp0 got %b/%h want 1/a0a0a0a0", out3.mem_ready, out3.mem_rdata); end
        tick(); tick();
        checks++; if (out3.mem_ready !== 1'b0 || out3.mem_rdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL l3_gap got %b/%h want 0/a0a0a0a0", out3.mem_ready, out3.mem_rdata); end
        tick();
        checks++; if (out3.mem_ready !== 1'b1 || out3.mem_rdata !== 32'hA4A4A4A4) begin failures++; $display("FAIL l3_rsp1 got %b/%h want 1/a4a4a4a4", out3.mem_ready, out3.mem_rdata); end
        n = 0;
        repeat (6) begin tick(); if (out3.mem_ready) n++; end
        checks++; if (n !== 0 || ov3 !== 1'b1) begin failures++; $display("FAIL l3_dropped_silent got readies=%0d ov=%b want 0 1", n, ov3); end
    endtask

    task automatic test_back_to_back();
        single(2, 2, 32'h0, 32'hB0B0B0B0, 4'hF); tick();
        single(2, 2, 32'h4, 32'hB4B4B4B4, 4'hF); tick();
        drive(2, 1'b1, 32'h0, 0, 0); tick();
        drive(2, 1'b0, 0, 0, 0); tick();
        checks++; if (out2.mem_ready !== 1'b0) begin failures++; $display("FAIL b2b_early got %b want 0", out2.mem_ready); end
        drive(2, 1'b1, 32'h4, 0, 0); tick();
        checks++; if (out2.mem_ready !== 1'b1 || out2.mem_rdata !== 32'hB0B0B0B0) begin failures++; $display("FAIL b2b_rsp0 got %b/%h want 1/b0b0b0b0", out2.mem_ready, out2.mem_rdata); end
        drive(2, 1'b0, 0, 0, 0); tick();
        checks++; if (out2.mem_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap got %b want 0", out2.mem_ready); end
        tick();
        checks++; if (out2.mem_ready !== 1'b1 || out2.mem_rdata !== 32'hB4B4B4B4) begin failures++; $display("FAIL b2b_rsp1 got %b/%h want 1/b4b4b4b4", out2.mem_ready, out2.mem_rdata); end
        tick();
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL b2b_ov got %b want 0", ov2); end
    endtask

    task automatic test_reset_busy();
        int n;
        single(3, 3, 32'h30, 32'hCAFEF00D, 4'hF); tick();
        single(3, 3, 32'h34, 32'h55555555, 4'hF); tick();
        drive(3, 1'b1, 32'h34, 32'h12345678, 4'hF); tick();
        drive(3, 1'b1, 32'h30, 32'h00000000, 4'hF); tick();
        drive(3, 1'b0, 0, 0, 0);
        reset = 1'b1; tick();
        reset = 1'b0;
        checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL rst_busy_ov got %b want 0", ov3); end
        n = 0;
        repeat (8) begin tick(); if (out3.mem_ready) n++; end
        checks++; if (n !== 0) begin failures++; $display("FAIL rst_busy_no_rsp got readies=%0d want 0", n); end
        single(3, 3, 32'h30, 0, 0);
        checks++; if (out3.mem_ready !== 1'b1 || out3.mem_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_keep30 got %b/%h want 1/cafef00d", out3.mem_ready, out3.mem_rdata); end
        tick();
        single(3, 3, 32'h34, 0, 0);
        checks++; if (out3.mem_rdata !== 32'h55555555) begin failures++; $display("FAIL rst_abandon34 got %h want 55555555", out3.mem_rdata); end
        tick();
    endtask

    task automatic test_range();
        logic [31:0] exp_rd, exp_w0;
        logic        exp_err;
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
        exp_rd = 32'h0;        exp_err = 1'b1; exp_w0 = 32'h0BADF00D;
`else
        exp_rd = 32'h0BADF00D; exp_err = 1'b0; exp_w0 = 32'hFFFFFFFF;
`endif
        single(1, 1, 32'h0, 32'h0BADF00D, 4'hF);
        checks++; if (er1 !== 1'b0) begin failures++; $display("FAIL range_inb_err got %b want 0", er1); end
        tick();
        single(1, 1, 32'h1000, 0, 0);
        checks++; if (out1.mem_ready !== 1'b1 || out1.mem_rdata !== exp_rd) begin failures++; $display("FAIL range_rd got %b/%h want 1/%h", out1.mem_ready, out1.mem_rdata, exp_rd); end
        checks++; if (er1 !== exp_err) begin failures++; $display("FAIL range_err got %b want %b", er1, exp_err); end
        tick();
        checks++; if (er1 !== 1'b0) begin failures++; $display("FAIL range_err_pulse got %b want 0", er1); end
        single(1, 1, 32'h1000, 32'hFFFFFFFF, 4'hF); tick();
        single(1, 1, 32'h0, 0, 0);
        checks++; if (out1.mem_rdata !== exp_w0) begin failures++; $display("FAIL range_wr_alias got %h want %h", out1.mem_rdata, exp_w0); end
        tick();
    endtask

    initial begin
        drive(1, 1'b0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0);
        drive(3, 1'b0, 0, 0, 0);
        test_reset();
        test_l1_write_read();
        test_byte_strobe();
        test_overrun_l3();
        test_back_to_back();
        test_reset_busy();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
